pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the 8-bit combinational barrel shifter.
- Shifts or rotates a WIDTH-bit operand left or right by 0..WIDTH-1 positions in logical, arithmetic or rotate mode.
- Has one register stage per log2 shift stage and a valid/ready handshake on input and output.
- Sits between an upstream operand producer and a downstream consumer in the datapath; carries a sideband tag so that ordering can be checked.

Parameters:
- WIDTH, 8, operand width; power of two, minimum 2.
- TAG_W, 4, width of the sideband tag carried alongside each operand.
- SHAMT_W, derived localparam = log2(WIDTH); also equals pipeline depth L.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- data_in  input  WIDTH  operand.
- shift_amt  input  SHAMT_W  shift or rotate count.
- dir  input  1  0 = left, 1 = right.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (behaves as logical).
- tag_in  input  TAG_W  sideband tag, passed through unmodified.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- data_out  output  WIDTH  result.
- tag_out  output  TAG_W  tag of the result.
- out_zero  output  1  data_out == 0 (qualified by out_valid).

Behaviour:
- Reset (async assert, sync release): all stage valid bits are 0; out_valid=0; data_out=0; tag_out=0; out_zero=0. in_ready=1 from the first cycle after release.
- Pipeline: L stages. Stage k (k=0..L-1) conditionally applies a shift of 2^k using bit k of the registered shift_amt, then registers the result, valid, tag, dir, mode and remaining shift_amt bits.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. The whole pipe moves one stage when adv=1 and holds completely when adv=0. Bubbles are not collapsed.
- Accept: a beat is taken when in_valid && in_ready. Its result appears with out_valid=1 exactly L cycles later if adv stays 1 throughout.
- Transfer: a result transfers when out_valid && out_ready.
- Stall: while out_valid && !out_ready, data_out, tag_out and out_zero are held stable. No beat is lost or duplicated. Ordering is strictly FIFO.
- Logical left: zero fill from LSB.
- Logical right: zero fill from MSB.
- Arithmetic right: fill with the original data_in MSB. The sign bit is captured at stage 0 and carried through.
- Arithmetic left: identical to logical left.
- Rotate: bits shifted out re-enter at the opposite end; with shift_amt=0 the operand is unchanged.
- shift_amt=0 in any mode: data_out == data_in.
- in_valid=0 cycles inject bubbles (valid=0). Stage data contents for bubbles are don't-care, but data_out is only updated when a valid result reaches the last stage.
- out_zero is registered together with data_out at the last stage.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values immediately.
- Inputs are sampled only on accept; changes while in_ready=0 have no effect.

Test Plan:
- WIDTH=8: accept 10110011, amt=1, dir=0, mode=00 -> after 3 cycles out_valid=1, data_out=01100110.
- 10110011, amt=3, dir=1, mode=01 -> 11110110. Same operand with mode=00 -> 00010110.
- Rotate with 10110011: amt=3, dir=1 -> 01110110; amt=2, dir=0 -> 11001110; amt=0 -> 10110011.
- Back-to-back 4 beats with tags 1..4 and out_ready held 0 from cycle 3 -> out_valid stuck with tag 1 and stable data, in_ready=0. Release out_ready -> tags 1,2,3,4 emerge in order, no loss or duplication.
- 00010000, amt=5, dir=1, mode=00 -> data_out=00000000, out_zero=1. 00000001, amt=7, dir=0 -> 10000000, out_zero=0.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0, data_out=0 immediately; after release, no stale results appear. Repeat the first scenario with WIDTH=32, amt=31, mode=01 on 0x80000000 -> 0xFFFFFFFF, latency 5.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter / rotator with a valid/ready handshake.
//
// Shifts or rotates a WIDTH-bit operand by 0..WIDTH-1 positions. There is one register
// stage per bit of the shift amount, so latency is log2(WIDTH) cycles. The whole pipe
// advances together (no bubble collapsing), which keeps ordering strictly FIFO.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; beat accepted when both are high
//   data_in             operand
//   shift_amt           shift/rotate count
//   dir                 0 = left, 1 = right
//   mode                00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   tag_in              sideband tag, passed through unmodified
//   out_valid/out_ready output handshake; result transfers when both are high
//   data_out, tag_out   result and its tag
//   out_zero            data_out == 0, registered alongside data_out
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               out_zero
);

  localparam int unsigned Depth = SHAMT_W;
  localparam int LastStage = int'(SHAMT_W) - 1;

  // Stage registers; index k holds the result after applying shift bit k.
  logic [Depth-1:0]   valid_q;
  logic [WIDTH-1:0]   data_q  [Depth];
  logic [TAG_W-1:0]   tag_q   [Depth];
  logic               dir_q   [Depth];
  logic [1:0]         mode_q  [Depth];
  logic [SHAMT_W-1:0] amt_q   [Depth];
  logic               sign_q  [Depth];
  logic               zero_q;

  // Stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1.
  logic [Depth-1:0]   st_v;
  logic [WIDTH-1:0]   st_d    [Depth];
  logic [TAG_W-1:0]   st_tag  [Depth];
  logic               st_dir  [Depth];
  logic [1:0]         st_mode [Depth];
  logic [SHAMT_W-1:0] st_amt  [Depth];
  logic               st_sign [Depth];
  logic [WIDTH-1:0]   res     [Depth];

  logic adv;

  // One fixed-distance step. Right arithmetic fills with the sign captured at stage 0;
  // since earlier steps already filled with that sign, the cumulative result is correct.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input int unsigned s,
                                            input logic right, input logic [1:0] md,
                                            input logic sign);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill_mask;
    fill_mask = ~({WIDTH{1'b1}} >> s);
    r = right ? (d >> s) : (d << s);
    if (md == 2'b10) begin
      r = right ? (r | (d << (WIDTH - s))) : (r | (d >> (WIDTH - s)));
    end else if (md == 2'b01 && right && sign) begin
      r = r | fill_mask;
    end
    return r;
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[Depth-1];
  assign data_out  = data_q[Depth-1];
  assign tag_out   = tag_q[Depth-1];
  assign out_zero  = zero_q;

  always_comb begin
    st_v[0]    = in_valid;
    st_d[0]    = data_in;
    st_tag[0]  = tag_in;
    st_dir[0]  = dir;
    st_mode[0] = mode;
    st_amt[0]  = shift_amt;
    st_sign[0] = data_in[WIDTH-1];
    for (int k = 1; k < int'(Depth); k++) begin
      st_v[k]    = valid_q[k-1];
      st_d[k]    = data_q[k-1];
      st_tag[k]  = tag_q[k-1];
      st_dir[k]  = dir_q[k-1];
      st_mode[k] = mode_q[k-1];
      st_amt[k]  = amt_q[k-1];
      st_sign[k] = sign_q[k-1];
    end
    for (int k = 0; k < int'(Depth); k++) begin
      res[k] = st_amt[k][k] ? step(st_d[k], 32'd1 << k, st_dir[k], st_mode[k], st_sign[k])
                            : st_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < int'(Depth); k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
        dir_q[k]  <= 1'b0;
        mode_q[k] <= '0;
        amt_q[k]  <= '0;
        sign_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < int'(Depth); k++) begin
        valid_q[k] <= st_v[k];
        // The output stage only loads real results so bubbles never disturb data_out.
        if (k != LastStage || st_v[k]) begin
          data_q[k] <= res[k];
          tag_q[k]  <= st_tag[k];
          dir_q[k]  <= st_dir[k];
          mode_q[k] <= st_mode[k];
          amt_q[k]  <= st_amt[k];
          sign_q[k] <= st_sign[k];
        end
      end
      if (st_v[Depth-1]) begin
        zero_q <= (res[Depth-1] == '0);
      end
    end
  end

endmodule
